fle_array_gen: RTL and testbench
================================

# fle_array_gen

Parametrised array of NUM_FLE fracturable logic elements, each with a K-input fracturable LUT, two flip-flops and configurable output/D-input routing. All configuration bits sit in one internal shift chain clocked by the fabric clock, with a load counter and a `cfg_done` status. It is the generalised successor of the single-FLE physical fabric and sits inside the CLB logical tile. It adds:
- per-FLE register-chain cascading;
- an FF scan chain across the array;
- gated outputs until configuration is complete.

## Interface
- K, 4, LUT inputs per FLE (≥2)
- NUM_FLE, 2, number of FLEs (≥1)
- W (derived), 2^K+4 config bits per FLE (2^K+6 with FLE_FF_INIT_EN); CFG_LEN = NUM_FLE*W
- clk  in  1  fabric clock; also shifts config
- rst_n  in  1  asynchronous, active-low reset
- cfg_en  in  1  shift config one bit per cycle
- cfg_in  in  1  config serial in
- cfg_out  out  1  config serial out, = sr[CFG_LEN-1]
- cfg_done  out  1  configuration complete
- test_en  in  1  scan mode
- fabric_in  in  NUM_FLE*K  LUT inputs; FLE f uses [f*K +: K]
- fabric_regin  in  1  register-chain input
- fabric_sc_in  in  1  scan-chain input
- fabric_out  out  2*NUM_FLE  FLE f drives [2f], [2f+1]
- fabric_regout  out  1  register-chain output
- fabric_sc_out  out  1  scan-chain output

## Operation
- Config register sr[CFG_LEN-1:0]; when cfg_en=1: sr <= {sr[CFG_LEN-2:0], cfg_in}.
- FLE f field is sr[f*W +: W], with these sub-fields from LSB:
  - LUT mem[2^K]
  - frac
  - out0_sel
  - out1_sel
  - d0_sel
  - (init0, init1 with macro)
- LUT, with lo = in[K-2:0]:
  - frac=1: lut0 = mem[lo], lut1 = mem[2^(K-1)+lo].
  - frac=0: lut0 = mem[in[K-1:0]], lut1 as fractured.
- FF0 D:
  - d0_sel=0 → lut0.
  - d0_sel=1 → chain input: fabric_regin for FLE 0, FF1.Q of FLE f-1 otherwise.
- FF1 D = lut1.
- fabric_out[2f] = out0_sel ? FF0.Q : lut0; fabric_out[2f+1] = out1_sel ? FF1.Q : lut1.
- All fabric_out forced 0 while cfg_done=0.
- fabric_regout = fabric_sc_out = FF1.Q of FLE NUM_FLE-1.
- Scan (test_en=1): FF D replaced by scan chain fabric_sc_in → FLE0.FF0 → FLE0.FF1 → FLE1.FF0 → … → last FF1.
- FF capture priority:
  1. cfg_en=1: hold.
  2. test_en=1: scan shift.
  3. cfg_done=1: functional D.
  4. Otherwise: hold.
- Load counter cnt (width clog2(CFG_LEN+1)), updated only when cfg_en=1:
  - cfg_done=1 → cnt <= 1 (reconfiguration restart).
  - Otherwise cnt <= min(cnt+1, CFG_LEN).
- cfg_done register: cfg_done <= (cnt==CFG_LEN) && !cfg_en.
- Over-shifting: extra bits still shift and spill out of cfg_out; cnt stays saturated, so the last CFG_LEN bits win.
- Under-shifting: cnt<CFG_LEN when cfg_en drops → cfg_done stays 0; resuming cfg_en continues counting.

## Timing
- Reset values (rst_n=0, async): sr=0, cnt=0, cfg_done=0, all FFs=0. Resulting outputs:
  - fabric_out=0
  - cfg_out=0
  - fabric_regout=0
  - fabric_sc_out=0
- Asserting rst_n mid-load discards progress; the full CFG_LEN shifts are needed again.
- cfg_out changes the edge after each shift; first pushed bit appears at cfg_out after CFG_LEN shifts.
- cfg_done rises on the first clk edge with cfg_en=0 after cnt reached CFG_LEN.
- cfg_done falls on the first edge with cfg_en=1.
- LUT paths are combinational (0 cycles); FF paths add 1 cycle.
- Register chain across FLEs: 2 cycles per FLE (FF0 then FF1 via lut1 only if configured; chain hop is FF1→next FF0).
- Scan chain delay: 2*NUM_FLE cycles from fabric_sc_in to fabric_sc_out.
- test_en and cfg_en both high: cfg_en wins, FFs hold.

## Configuration
- FLE_FF_INIT_EN defined:
  - W gains init0/init1 bits.
  - On the edge where cfg_done goes 0→1, each FF loads its init bit instead of capturing.
  - Later edges behave normally.
- FLE_FF_INIT_EN undefined:
  - W = 2^K+4.
  - FFs remain at reset value 0 until first capture.

## Test plan
All scenarios use K=4, NUM_FLE=2, macro undefined, CFG_LEN=40.
- Reset mid-load: shift 25 bits, pulse rst_n low → cfg_done=0, all outputs 0; then 40 shifts with cfg_en dropping → cfg_done=1 one cycle later.
- Unfractured LUT: FLE0 mem=16'h8000, frac=0, out0_sel=0 → fabric_in[3:0]=4'hF gives fabric_out[0]=1, 4'hE gives 0; before cfg_done, fabric_out=0.
- Fractured registered: FLE1 frac=1, upper half all 1, out1_sel=1 → fabric_out[3] goes 1 exactly one cycle after cfg_done rises.
- Register chain: d0_sel=1 in both FLEs, lut1 = pass of FF0 via … → fabric_regin pulse appears at fabric_regout after the configured cycle count.
- Scan: test_en=1, fabric_sc_in pattern 1,0,1,1 → fabric_sc_out reproduces it 4 cycles later; with cfg_en=1 simultaneously, FFs hold.
- Over-shift: 45 shifts → cnt saturates, cfg_done=1, config equals the last 40 bits, and the first 5 bits appeared on cfg_out.

Source files
------------

// File: rtl/fle_array_gen.sv
// Array of fracturable logic elements with a serial configuration chain, a register chain and a scan chain.
// Optional FF init-on-configure feature is enabled by defining FLE_FF_INIT_EN.
module fle_array_gen #(
   parameter int K       = 4,
   parameter int NUM_FLE = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cfg_en,
   input  logic                   cfg_in,
   output logic                   cfg_out,
   output logic                   cfg_done,
   input  logic                   test_en,
   input  logic [NUM_FLE*K-1:0]   fabric_in,
   input  logic                   fabric_regin,
   input  logic                   fabric_sc_in,
   output logic [2*NUM_FLE-1:0]   fabric_out,
   output logic                   fabric_regout,
   output logic                   fabric_sc_out
);

   localparam int MEM = 1 << K;
`ifdef FLE_FF_INIT_EN
   localparam int W = MEM + 6;
`else
   localparam int W = MEM + 4;
`endif
   localparam int CFG_LEN = NUM_FLE * W;
   localparam int CW      = $clog2(CFG_LEN + 1);

   logic [CFG_LEN-1:0] r_sr;
   logic [CW-1:0]      r_cnt;
   logic               r_cfg_done;
   logic [NUM_FLE-1:0] r_ff0;
   logic [NUM_FLE-1:0] r_ff1;

   logic [NUM_FLE-1:0] w_d0;
   logic [NUM_FLE-1:0] w_d1;
   logic [NUM_FLE-1:0] w_scan0;
`ifdef FLE_FF_INIT_EN
   logic [NUM_FLE-1:0] w_init0;
   logic [NUM_FLE-1:0] w_init1;
   logic               w_done_rise;
`endif
   logic               w_cnt_full;

   assign w_cnt_full = (r_cnt == CW'(CFG_LEN));

   for (genvar f = 0; f < NUM_FLE; f++) begin : g_fle
      logic [W-1:0]   w_field;
      logic [MEM-1:0] w_mem;
      logic [K-2:0]   w_lo;
      logic [K-1:0]   w_idx;
      logic           w_frac;
      logic           w_out0_sel;
      logic           w_out1_sel;
      logic           w_d0_sel;
      logic           w_lut0;
      logic           w_lut1;
      logic           w_chain;

      assign w_field    = r_sr[f*W +: W];
      assign w_mem      = w_field[MEM-1:0];
      assign w_frac     = w_field[MEM];
      assign w_out0_sel = w_field[MEM+1];
      assign w_out1_sel = w_field[MEM+2];
      assign w_d0_sel   = w_field[MEM+3];
      assign w_lo       = fabric_in[f*K +: K-1];
      assign w_idx      = fabric_in[f*K +: K];

      // lut1 always reads the upper half; lut0 spans the full table when unfractured
      assign w_lut1 = w_mem[{1'b1, w_lo}];
      assign w_lut0 = w_frac ? w_mem[{1'b0, w_lo}] : w_mem[w_idx];

      if (f == 0) begin : g_first
         assign w_chain    = fabric_regin;
         assign w_scan0[f] = fabric_sc_in;
      end else begin : g_rest
         assign w_chain    = r_ff1[f-1];
         assign w_scan0[f] = r_ff1[f-1];
      end

      assign w_d0[f] = w_d0_sel ? w_chain : w_lut0;
      assign w_d1[f] = w_lut1;

`ifdef FLE_FF_INIT_EN
      assign w_init0[f] = w_field[MEM+4];
      assign w_init1[f] = w_field[MEM+5];
`endif

      assign fabric_out[2*f]   = r_cfg_done & (w_out0_sel ? r_ff0[f] : w_lut0);
      assign fabric_out[2*f+1] = r_cfg_done & (w_out1_sel ? r_ff1[f] : w_lut1);
   end

`ifdef FLE_FF_INIT_EN
   assign w_done_rise = w_cnt_full && !cfg_en && !r_cfg_done;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sr       <= '0;
         r_cnt      <= '0;
         r_cfg_done <= 1'b0;
      end else begin
         r_cfg_done <= w_cnt_full && !cfg_en;
         if (cfg_en) begin
            r_sr <= {r_sr[CFG_LEN-2:0], cfg_in};
            // a shift while configured restarts the load; otherwise saturate
            if (r_cfg_done)
               r_cnt <= CW'(1);
            else if (!w_cnt_full)
               r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ff0 <= '0;
         r_ff1 <= '0;
      end else if (cfg_en) begin
         r_ff0 <= r_ff0;
         r_ff1 <= r_ff1;
`ifdef FLE_FF_INIT_EN
      end else if (w_done_rise) begin
         r_ff0 <= w_init0;
         r_ff1 <= w_init1;
`endif
      end else if (test_en) begin
         r_ff0 <= w_scan0;
         r_ff1 <= r_ff0;
      end else if (r_cfg_done) begin
         r_ff0 <= w_d0;
         r_ff1 <= w_d1;
      end
   end

   assign cfg_out       = r_sr[CFG_LEN-1];
   assign cfg_done      = r_cfg_done;
   assign fabric_regout = r_ff1[NUM_FLE-1];
   assign fabric_sc_out = r_ff1[NUM_FLE-1];

endmodule

// File: tb/tb_fle_array_gen.sv
// Directed bench for fle_array_gen with K=4, NUM_FLE=2 (CFG_LEN=40).
module tb_fle_array_gen;
   localparam int K  = 4;
   localparam int NF = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cfg_en;
   logic       cfg_in;
   logic       test_en;
   logic       fabric_regin;
   logic       fabric_sc_in;
   logic       cfg_out;
   logic       cfg_done;
   logic       fabric_regout;
   logic       fabric_sc_out;
   logic [3:0] fabric_out;
   logic [7:0] in_drv;
   logic       fb_mode;
   wire  [7:0] fabric_in;

   int tests = 0;
   int fails = 0;

   // feedback mode loops each FLE's out0 back into its LUT input 0
   assign fabric_in = fb_mode ? {in_drv[7:5], fabric_out[2], in_drv[3:1], fabric_out[0]} : in_drv;

   fle_array_gen #(.K(K), .NUM_FLE(NF)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cfg_en        (cfg_en),
      .cfg_in        (cfg_in),
      .cfg_out       (cfg_out),
      .cfg_done      (cfg_done),
      .test_en       (test_en),
      .fabric_in     (fabric_in),
      .fabric_regin  (fabric_regin),
      .fabric_sc_in  (fabric_sc_in),
      .fabric_out    (fabric_out),
      .fabric_regout (fabric_regout),
      .fabric_sc_out (fabric_sc_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [19:0] fle(input logic d0, input logic o1, input logic o0,
                                       input logic fr, input logic [15:0] mem);
      return {d0, o1, o0, fr, mem};
   endfunction

   task automatic shift_bit(input logic b);
      cfg_en = 1'b1;
      cfg_in = b;
      tick();
   endtask

   task automatic shift_cfg(input logic [39:0] c);
      for (int i = 39; i >= 0; i--) shift_bit(c[i]);
   endtask

   task automatic finish_load();
      cfg_en = 1'b0;
      cfg_in = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cfg_en = 1'b0; cfg_in = 1'b0; test_en = 1'b0;
      fabric_regin = 1'b0; fabric_sc_in = 1'b0; in_drv = 8'h00; fb_mode = 1'b0;
      #22;
      tests++;
      if ({cfg_done, cfg_out, fabric_regout, fabric_sc_out, fabric_out} !== 8'h00) begin
         fails++;
         $display("FAIL reset_outputs: got %b want 00000000",
                  {cfg_done, cfg_out, fabric_regout, fabric_sc_out, fabric_out});
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset_mid_load();
      for (int i = 0; i < 25; i++) shift_bit(1'b1);
      cfg_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      tests++;
      if ({cfg_done, cfg_out, fabric_regout, fabric_sc_out, fabric_out} !== 8'h00) begin
         fails++;
         $display("FAIL midload_reset_outputs: got %b want 00000000",
                  {cfg_done, cfg_out, fabric_regout, fabric_sc_out, fabric_out});
      end
      #1;
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 39; i++) shift_bit(1'b0);
      cfg_en = 1'b0;
      tick();
      tick();
      tests++;
      if (cfg_done !== 1'b0) begin
         fails++;
         $display("FAIL undershift_done: got %b want 0", cfg_done);
      end
      shift_bit(1'b0);
      tests++;
      if (cfg_done !== 1'b0) begin
         fails++;
         $display("FAIL done_while_shifting: got %b want 0", cfg_done);
      end
      finish_load();
      tests++;
      if (cfg_done !== 1'b1) begin
         fails++;
         $display("FAIL done_after_load: got %b want 1", cfg_done);
      end
   endtask

   task automatic test_unfractured();
      fb_mode = 1'b0;
      shift_cfg({fle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000), fle(1'b0, 1'b0, 1'b0, 1'b0, 16'h8000)});
      cfg_en = 1'b0;
      in_drv = 8'h0F;
      #1;
      tests++;
      if ({cfg_done, fabric_out} !== 5'b00000) begin
         fails++;
         $display("FAIL gated_before_done: got %b want 00000", {cfg_done, fabric_out});
      end
      finish_load();
      tests++;
      if ({cfg_done, fabric_out} !== 5'b10011) begin
         fails++;
         $display("FAIL unfrac_in_F: got %b want 10011", {cfg_done, fabric_out});
      end
      in_drv = 8'h0E;
      #1;
      tests++;
      if (fabric_out !== 4'b0000) begin
         fails++;
         $display("FAIL unfrac_in_E: got %b want 0000", fabric_out);
      end
      in_drv = 8'hF7;
      #1;
      tests++;
      if (fabric_out !== 4'b0010) begin
         fails++;
         $display("FAIL unfrac_in_7: got %b want 0010", fabric_out);
      end
      in_drv = 8'h00;
   endtask

   task automatic test_fractured_reg();
      shift_cfg({fle(1'b0, 1'b1, 1'b0, 1'b1, 16'hFF00), fle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000)});
      finish_load();
      tests++;
      if ({cfg_done, fabric_out} !== 5'b10000) begin
         fails++;
         $display("FAIL frac_reg_at_done: got %b want 10000", {cfg_done, fabric_out});
      end
      tick();
      tests++;
      if ({fabric_regout, fabric_out} !== 5'b11000) begin
         fails++;
         $display("FAIL frac_reg_next: got %b want 11000", {fabric_regout, fabric_out});
      end
   endtask

   task automatic test_reg_chain();
      fb_mode = 1'b1;
      in_drv = 8'h00;
      fabric_regin = 1'b0;
      shift_cfg({fle(1'b1, 1'b0, 1'b1, 1'b1, 16'hAA00), fle(1'b1, 1'b0, 1'b1, 1'b1, 16'hAA00)});
      finish_load();
      for (int i = 0; i < 6; i++) tick();
      tests++;
      if (fabric_regout !== 1'b0) begin
         fails++;
         $display("FAIL chain_flushed: got %b want 0", fabric_regout);
      end
      fabric_regin = 1'b1;
      tick();
      fabric_regin = 1'b0;
      tests++;
      if (fabric_out[0] !== 1'b1) begin
         fails++;
         $display("FAIL chain_ff0_capture: got %b want 1", fabric_out[0]);
      end
      for (int n = 2; n <= 6; n++) begin
         tick();
         tests++;
         if (fabric_regout !== (n == 4)) begin
            fails++;
            $display("FAIL chain_edge%0d: got %b want %b", n, fabric_regout, (n == 4));
         end
      end
      fb_mode = 1'b0;
   endtask

   task automatic test_scan();
      logic [7:0] pat;
      logic       exp_b;
      pat = 8'b0000_1101;
      test_en = 1'b1;
      fabric_sc_in = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      for (int k = 0; k < 4; k++) begin
         fabric_sc_in = pat[k];
         tick();
         exp_b = (k >= 3) ? pat[k-3] : 1'b0;
         tests++;
         if (fabric_sc_out !== exp_b) begin
            fails++;
            $display("FAIL scan_k%0d: got %b want %b", k, fabric_sc_out, exp_b);
         end
      end
      cfg_en = 1'b1;
      fabric_sc_in = 1'b0;
      for (int h = 0; h < 3; h++) begin
         tick();
         tests++;
         if (fabric_sc_out !== pat[0]) begin
            fails++;
            $display("FAIL scan_hold%0d: got %b want %b", h, fabric_sc_out, pat[0]);
         end
      end
      cfg_en = 1'b0;
      for (int k = 4; k < 8; k++) begin
         fabric_sc_in = pat[k];
         tick();
         tests++;
         if (fabric_sc_out !== pat[k-3]) begin
            fails++;
            $display("FAIL scan_k%0d: got %b want %b", k, fabric_sc_out, pat[k-3]);
         end
      end
      test_en = 1'b0;
      fabric_sc_in = 1'b0;
   endtask

   task automatic test_overshift();
      logic [44:0] s;
      s = {5'b10110, fle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000), fle(1'b0, 1'b0, 1'b0, 1'b0, 16'h8000)};
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      for (int n = 1; n <= 45; n++) begin
         shift_bit(s[45-n]);
         if (n >= 40 && n <= 44) begin
            tests++;
            if (cfg_out !== s[84-n]) begin
               fails++;
               $display("FAIL overshift_cfg_out_n%0d: got %b want %b", n, cfg_out, s[84-n]);
            end
         end
      end
      in_drv = 8'h0F;
      finish_load();
      tests++;
      if ({cfg_done, fabric_out} !== 5'b10011) begin
         fails++;
         $display("FAIL overshift_func_F: got %b want 10011", {cfg_done, fabric_out});
      end
      in_drv = 8'h0E;
      #1;
      tests++;
      if (fabric_out !== 4'b0000) begin
         fails++;
         $display("FAIL overshift_func_E: got %b want 0000", fabric_out);
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid_load();
      test_unfractured();
      test_fractured_reg();
      test_reg_chain();
      test_scan();
      test_overshift();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
